// File: rtl/fp_factorial_sequencer.sv
// Iterative n! sequencer that drives an external combinational FP multiplier,
// one multiplication per clock, with sticky overflow/underflow reporting.
module fp_factorial_sequencer #(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23,
   parameter int N_WIDTH        = 6
) (
   input  logic                                  clk_in,
   input  logic                                  rst_n_in,
   input  logic                                  start_in,
   input  logic [N_WIDTH-1:0]                    n_in,
   output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     a_out,
   output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     b_out,
   input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     prod_in,
   input  logic                                  mult_overflow_in,
   input  logic                                  mult_underflow_in,
   output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     result_out,
   output logic                                  busy_out,
   output logic                                  done_out,
   output logic                                  overflow_out,
   output logic                                  underflow_out
);

   localparam int W    = 1 + EXP_WIDTH + MANTISSA_WIDTH;
   localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;

   localparam logic [W-1:0] ONE_FP =
      {1'b0, EXP_WIDTH'(BIAS), {MANTISSA_WIDTH{1'b0}}};

   generate
      if (N_WIDTH > MANTISSA_WIDTH + 1) begin : g_bad_cfg
         $error("N_WIDTH must not exceed MANTISSA_WIDTH+1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DONE
   } state_t;

   // Exact integer-to-float: leading one becomes the hidden bit.
   function automatic logic [W-1:0] int2fp(input logic [N_WIDTH-1:0] v);
      logic [MANTISSA_WIDTH:0] ext;
      logic [EXP_WIDTH-1:0]    e;
      int                      p;
      p = 0;
      for (int k = 0; k < N_WIDTH; k++) begin
         if (v[k]) p = k;
      end
      ext = (MANTISSA_WIDTH+1)'(v) << (MANTISSA_WIDTH - p);
      e   = EXP_WIDTH'(BIAS + p);
      if (v == '0) int2fp = '0;
      else         int2fp = {1'b0, e, ext[MANTISSA_WIDTH-1:0]};
   endfunction

   state_t             state_q;
   logic [N_WIDTH-1:0] n_q;
   logic [N_WIDTH-1:0] i_q;
   logic [N_WIDTH-1:0] i_d;
   logic [W-1:0]       b_d;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       res_q;
   logic               busy_q;
   logic               done_q;
   logic               ovf_q;
   logic               unf_q;
   logic               last_w;

   assign i_d    = i_q + N_WIDTH'(1);
   assign b_d    = int2fp(i_d);
   assign last_w = (i_q == n_q) || mult_overflow_in;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         i_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  n_q   <= n_in;
                  ovf_q <= 1'b0;
                  unf_q <= 1'b0;
                  if (n_in <= N_WIDTH'(1)) begin
                     res_q   <= ONE_FP;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     a_q     <= ONE_FP;
                     i_q     <= N_WIDTH'(2);
                     b_q     <= int2fp(N_WIDTH'(2));
                     busy_q  <= 1'b1;
                     state_q <= S_MULT;
                  end
               end
            end
            S_MULT: begin
               a_q   <= prod_in;
               ovf_q <= ovf_q | mult_overflow_in;
               unf_q <= unf_q | mult_underflow_in;
               // Overflow ends the run early; underflow is only recorded.
               if (last_w) begin
                  res_q   <= prod_in;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  i_q <= i_d;
                  b_q <= b_d;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign a_out         = a_q;
   assign b_out         = b_q;
   assign result_out    = res_q;
   assign busy_out      = busy_q;
   assign done_out      = done_q;
   assign overflow_out  = ovf_q;
   assign underflow_out = unf_q;

endmodule

// File: tb/tb_fp_factorial_sequencer.sv
// Bench for fp_factorial_sequencer with a behavioural single-precision
// multiplier (round-to-nearest-even) closing the loop on prod_in.
module tb_fp_factorial_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [5:0]  n;
   logic [31:0] a, b, prod, res;
   logic        movf, munf, busy, done, ovf, unf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [33:0] fpmul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0] p;
      logic [24:0] m;
      logic        g, s;
      int          e;
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return 34'd0;
      p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (p[47]) e = e + 1;
      else       p = p << 1;
      g = p[23];
      s = |p[22:0];
      m = {1'b0, p[47:24]} + 25'(g && (s || p[24]));
      if (m[24]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e >= 255) return {2'b10, 32'h7F800000};
      if (e <= 0)   return {2'b01, 32'h00000000};
      return {2'b00, 1'b0, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] i2f(input int v);
      int p;
      p = 0;
      for (int k = 0; k < 31; k++) if (v >= (1 << k)) p = k;
      return {1'b0, 8'(127 + p), 23'((v - (1 << p)) << (23 - p))};
   endfunction

   always_comb {movf, munf, prod} = fpmul(a, b);

   fp_factorial_sequencer dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .start_in         (start),
      .n_in             (n),
      .a_out            (a),
      .b_out            (b),
      .prod_in          (prod),
      .mult_overflow_in (movf),
      .mult_underflow_in(munf),
      .result_out       (res),
      .busy_out         (busy),
      .done_out         (done),
      .overflow_out     (ovf),
      .underflow_out    (unf)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          n;
      logic [31:0] res;
      bit          chk_res;
      bit          ovf;
      int          cyc;
      bit          hold;
   } vec_t;

   vec_t vt[8];

   task automatic run(input vec_t v);
      int cyc;
      int nb;
      bit seen;
      cyc  = 0;
      nb   = 0;
      seen = 0;
      @(negedge clk);
      n     = 6'(v.n);
      start = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1;
      if (v.hold) n = 6'd7;
      else        start = 1'b0;
      while (cyc < 200) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) begin
            chk($sformatf("b_out n=%0d k=%0d", v.n, nb + 2), b, i2f(nb + 2));
            nb++;
         end
         @(posedge clk);
         cyc++;
      end
      start = 1'b0;
      chk($sformatf("done_seen n=%0d", v.n), 32'(seen), 32'd1);
      chk($sformatf("latency n=%0d", v.n), 32'(cyc), 32'(v.cyc));
      chk($sformatf("busy_cycles n=%0d", v.n), 32'(nb), 32'(v.n >= 2 ? v.cyc - 1 : 0));
      if (v.chk_res) chk($sformatf("result n=%0d", v.n), res, v.res);
      chk($sformatf("overflow n=%0d", v.n), 32'(ovf), 32'(v.ovf));
      chk($sformatf("underflow n=%0d", v.n), 32'(unf), 32'd0);
      @(negedge clk);
      chk($sformatf("done_pulse n=%0d", v.n), 32'(done), 32'd0);
      chk($sformatf("busy_after n=%0d", v.n), 32'(busy), 32'd0);
      if (v.chk_res) chk($sformatf("result_hold n=%0d", v.n), res, v.res);
   endtask

   initial begin
      logic [31:0] acc;
      logic [33:0] r;
      bit          stray;

      acc = 32'h3F800000;
      for (int i = 2; i <= 20; i++) begin
         r   = fpmul(acc, i2f(i));
         acc = r[31:0];
      end

      vt[0] = '{n: 5,  res: 32'h42F00000, chk_res: 1, ovf: 0, cyc: 5,  hold: 0};
      vt[1] = '{n: 0,  res: 32'h3F800000, chk_res: 1, ovf: 0, cyc: 1,  hold: 0};
      vt[2] = '{n: 1,  res: 32'h3F800000, chk_res: 1, ovf: 0, cyc: 1,  hold: 0};
      vt[3] = '{n: 10, res: 32'h4A5D7C00, chk_res: 1, ovf: 0, cyc: 10, hold: 0};
      vt[4] = '{n: 40, res: 32'h0,        chk_res: 0, ovf: 1, cyc: 35, hold: 0};
      vt[5] = '{n: 3,  res: 32'h40C00000, chk_res: 1, ovf: 0, cyc: 3,  hold: 0};
      vt[6] = '{n: 20, res: acc,          chk_res: 1, ovf: 0, cyc: 20, hold: 1};
      vt[7] = '{n: 4,  res: 32'h41C00000, chk_res: 1, ovf: 0, cyc: 4,  hold: 0};

      rst_n = 1'b0;
      start = 1'b0;
      n     = 6'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset a_out", a, 32'h0);
      chk("reset b_out", b, 32'h0);
      chk("reset result", res, 32'h0);
      chk("reset flags", {28'h0, busy, done, ovf, unf}, 32'h0);
      rst_n = 1'b1;

      for (int t = 0; t < 7; t++) run(vt[t]);

      // Reset asserted in the middle of a 20! run.
      @(negedge clk);
      n     = 6'd20;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrun busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst a_out", a, 32'h0);
      chk("midrst b_out", b, 32'h0);
      chk("midrst result", res, 32'h0);
      chk("midrst flags", {28'h0, busy, done, ovf, unf}, 32'h0);
      rst_n = 1'b1;
      stray = 0;
      repeat (4) begin
         @(negedge clk);
         if (done || busy) stray = 1;
      end
      chk("midrst idle", 32'(stray), 32'd0);

      run(vt[7]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
